// File: rtl/m2v_idct.sv
// m2v_idct: 8x8 fixed-point inverse DCT with double-buffered
// residual output, one serial MAC shared by row and column passes.
module m2v_idct (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              softreset,
  output logic              ready_idct,
  input  logic              block_start,
  input  logic              s2_enable,
  input  logic              s2_coded,
  input  logic              s3_enable,
  input  logic              s3_coded,
  output logic              coef_next,
  input  logic              coef_sign,
  input  logic [11:0]       coef_data,
  input  logic              pixel_coded,
  input  logic [4:0]        pixel_addr,
  output logic signed [8:0] pixel_data0,
  output logic signed [8:0] pixel_data1
);

  typedef enum logic [2:0] {
    IDLE, SKIP, LOAD, ROWPASS, COLPASS
  } state_t;

  state_t state, state_n;
  logic [8:0] cnt, cnt_n;
  logic       sel;
  logic       zero;
  logic       start_ok;
  logic [5:0] o;
  logic [2:0] k;

  logic signed [12:0] fbuf [64];
  logic signed [15:0] rbuf [64];
  logic signed [8:0]  pbuf [128];

  logic signed [15:0] opa;
  logic signed [12:0] opc;
  logic signed [31:0] a32, c32, prod;
  logic signed [31:0] acc, sum, rsh, csh;
  logic signed [15:0] rsat;
  logic signed [8:0]  pclip;

  function automatic logic signed [12:0] ctab(
    input logic [2:0] u,
    input logic [2:0] x
  );
    logic [4:0]  m;
    logic [4:0]  i;
    logic        neg;
    logic [11:0] mag;
    m = 5'({x, 1'b1}) * 5'(u);
    if (m > 5'd16) m = 5'd0 - m;
    neg = m > 5'd8;
    i = neg ? 5'd16 - m : m;
    case (i)
      5'd0:    mag = 12'd2048;
      5'd1:    mag = 12'd2009;
      5'd2:    mag = 12'd1892;
      5'd3:    mag = 12'd1703;
      5'd4:    mag = 12'd1448;
      5'd5:    mag = 12'd1138;
      5'd6:    mag = 12'd784;
      5'd7:    mag = 12'd400;
      default: mag = 12'd0;
    endcase
    if (u == 3'd0) begin
      mag = 12'd1448;
      neg = 1'b0;
    end
    ctab = neg ? -$signed({1'b0, mag})
               :  $signed({1'b0, mag});
  endfunction

  assign o = cnt[8:3];
  assign k = cnt[2:0];
  assign start_ok = block_start && (state == IDLE);

  // next state, counter and handshake outputs
  always_comb begin
    state_n    = state;
    cnt_n      = cnt + 9'd1;
    ready_idct = 1'b0;
    coef_next  = 1'b0;
    unique case (state)
      IDLE: begin
        ready_idct = 1'b1;
        if (start_ok)
          state_n = (s2_enable && s2_coded) ? LOAD : SKIP;
      end
      SKIP: state_n = IDLE;
      LOAD: begin
        coef_next = ~cnt[0];
        if (cnt == 9'd127) state_n = ROWPASS;
      end
      ROWPASS: if (cnt == 9'd511) state_n = COLPASS;
      COLPASS: if (cnt == 9'd511) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (state_n != state) cnt_n = 9'd0;
  end

  // control state, bank select and MAC accumulator
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 9'd0;
      sel   <= 1'b0;
      zero  <= 1'b1;
      acc   <= 32'sd0;
    end else if (softreset) begin
      state <= IDLE;
      cnt   <= 9'd0;
      sel   <= 1'b0;
      zero  <= 1'b1;
      acc   <= 32'sd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (start_ok && s3_enable) begin
        sel  <= ~sel;
        zero <= ~s3_coded;
      end
      if (state == ROWPASS || state == COLPASS)
        acc <= sum;
    end
  end

  // MAC operand select, rounding, saturation and clipping
  always_comb begin
    if (state == COLPASS) begin
      opa = rbuf[{k, o[2:0]}];
      opc = ctab(k, o[5:3]);
    end else begin
      opa = {{3{fbuf[{o[5:3], k}][12]}}, fbuf[{o[5:3], k}]};
      opc = ctab(k, o[2:0]);
    end
    a32  = $signed({{16{opa[15]}}, opa});
    c32  = $signed({{19{opc[12]}}, opc});
    prod = a32 * c32;
    sum  = ((k == 3'd0) ? 32'sd0 : acc) + prod;
    rsh  = (sum + 32'sd256) >>> 9;
    csh  = (sum + 32'sd16384) >>> 15;
    if (rsh > 32'sd32767)       rsat = 16'sh7fff;
    else if (rsh < -32'sd32768) rsat = 16'sh8000;
    else                        rsat = rsh[15:0];
    if (csh > 32'sd255)         pclip = 9'sh0ff;
    else if (csh < -32'sd256)   pclip = 9'sh100;
    else                        pclip = csh[8:0];
  end

  // coefficient, intermediate and pixel storage
  always_ff @(posedge clk) begin
    if (coef_next)
      fbuf[cnt[6:1]] <= coef_sign ? -$signed({1'b0, coef_data})
                                  :  $signed({1'b0, coef_data});
    if (state == ROWPASS && k == 3'd7)
      rbuf[o] <= rsat;
    if (state == COLPASS && k == 3'd7)
      pbuf[{~sel, o}] <= pclip;
  end

  // registered pixel-pair read from the output bank
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_data0 <= 9'sd0;
      pixel_data1 <= 9'sd0;
    end else if (softreset) begin
      pixel_data0 <= 9'sd0;
      pixel_data1 <= 9'sd0;
    end else if (pixel_coded && !zero) begin
      pixel_data0 <= pbuf[{sel, pixel_addr, 1'b0}];
      pixel_data1 <= pbuf[{sel, pixel_addr, 1'b1}];
    end else begin
      pixel_data0 <= 9'sd0;
      pixel_data1 <= 9'sd0;
    end
  end

endmodule

// File: tb/tb_m2v_idct.sv
// tb_m2v_idct: DC-table vectors, pipeline corner cases and random
// blocks checked against a floating-point-derived IDCT model.
module tb_m2v_idct;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              softreset = 1'b0;
  logic              ready_idct;
  logic              block_start = 1'b0;
  logic              s2_enable = 1'b0;
  logic              s2_coded = 1'b0;
  logic              s3_enable = 1'b0;
  logic              s3_coded = 1'b0;
  logic              coef_next;
  logic              coef_sign = 1'b0;
  logic [11:0]       coef_data = 12'd0;
  logic              pixel_coded = 1'b0;
  logic [4:0]        pixel_addr = 5'd0;
  logic signed [8:0] pixel_data0;
  logic signed [8:0] pixel_data1;

  m2v_idct dut (
    .clk(clk), .reset_n(reset_n), .softreset(softreset),
    .ready_idct(ready_idct), .block_start(block_start),
    .s2_enable(s2_enable), .s2_coded(s2_coded),
    .s3_enable(s3_enable), .s3_coded(s3_coded),
    .coef_next(coef_next), .coef_sign(coef_sign),
    .coef_data(coef_data), .pixel_coded(pixel_coded),
    .pixel_addr(pixel_addr), .pixel_data0(pixel_data0),
    .pixel_data1(pixel_data1)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit sgn;
    int mag;
    int exp_pix;
  } dc_t;

  int  errors = 0;
  int  checks = 0;
  int  cur_f [64];
  int  ct [8][8];
  int  comp_pix [64];
  int  out_pix [64];
  bit  comp_known = 0;
  bit  out_known = 0;
  int  nstrobe = 0;
  bit  prev_strobe = 0;
  dc_t tbl [5];

  // upstream coefficient source: one value per consumed strobe
  always @(negedge clk) begin
    if (prev_strobe) nstrobe++;
    if (nstrobe < 64) begin
      coef_sign = cur_f[nstrobe] < 0;
      coef_data = 12'(cur_f[nstrobe] < 0 ? -cur_f[nstrobe]
                                         : cur_f[nstrobe]);
    end else begin
      coef_sign = 1'b0;
      coef_data = 12'd0;
    end
    prev_strobe = coef_next;
  end

  task automatic check(input string name, input int act,
                       input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void init_table;
    real pi, cu, v;
    pi = 3.14159265358979;
    for (int u = 0; u < 8; u++)
      for (int x = 0; x < 8; x++) begin
        cu = (u == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        v = 4096.0 * cu / 2.0 * $cos((2 * x + 1) * u * pi / 16.0);
        ct[u][x] = $rtoi($floor(v + 0.5));
      end
  endfunction

  function automatic void model_idct;
    longint s;
    int r [64];
    for (int v = 0; v < 8; v++)
      for (int x = 0; x < 8; x++) begin
        s = 0;
        for (int u = 0; u < 8; u++)
          s += longint'(cur_f[8 * v + u]) * ct[u][x];
        s = (s + 256) >>> 9;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        r[8 * v + x] = int'(s);
      end
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        s = 0;
        for (int v = 0; v < 8; v++)
          s += longint'(r[8 * v + x]) * ct[v][y];
        s = (s + 16384) >>> 15;
        if (s > 255) s = 255;
        if (s < -256) s = -256;
        comp_pix[8 * y + x] = int'(s);
      end
  endfunction

  function automatic void rand_block(input int dens);
    int m;
    for (int i = 0; i < 64; i++) begin
      cur_f[i] = 0;
      if ($urandom_range(0, 7) < dens) begin
        m = int'($urandom_range(0, 4095) >> $urandom_range(0, 11));
        cur_f[i] = $urandom_range(0, 1) ? -m : m;
      end
    end
  endfunction

  task automatic do_block(input bit s2e, input bit s2c,
                          input bit s3e, input bit s3c,
                          input int busy_at);
    int n;
    bit coded;
    coded = s2e && s2c;
    if (s3e) begin
      out_known = s3c ? comp_known : 1'b1;
      for (int i = 0; i < 64; i++)
        out_pix[i] = s3c ? comp_pix[i] : 0;
    end
    if (coded) begin
      model_idct();
      comp_known = 1'b1;
    end
    nstrobe = 0;
    prev_strobe = 0;
    s2_enable = s2e;
    s2_coded = s2c;
    s3_enable = s3e;
    s3_coded = s3c;
    block_start = 1'b1;
    tick();
    block_start = 1'b0;
    check("ready_drop", ready_idct, 0);
    n = 0;
    while (!ready_idct && n < 1500) begin
      if (n == busy_at) begin
        block_start = 1'b1;
        s3_enable = 1'b1;
        s3_coded = 1'b0;
      end else begin
        block_start = 1'b0;
      end
      tick();
      n++;
    end
    block_start = 1'b0;
    check("ready_back", ready_idct, 1);
    if (coded) check("latency_le_1200", int'(n + 1 <= 1200), 1);
    else       check("skip_latency", n, 1);
    check("strobes", nstrobe, coded ? 64 : 0);
  endtask

  task automatic read_all(input bit rnd_pc);
    bit pc;
    for (int a = 0; a < 32; a++) begin
      pc = rnd_pc ? ($urandom_range(0, 3) != 0) : 1'b1;
      pixel_addr = 5'(a);
      pixel_coded = pc;
      tick();
      if (out_known || !pc) begin
        check("pix0", pixel_data0, pc ? out_pix[2 * a] : 0);
        check("pix1", pixel_data1, pc ? out_pix[2 * a + 1] : 0);
      end
    end
    pixel_coded = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    init_table();
    for (int i = 0; i < 64; i++) cur_f[i] = 0;
    tbl[0] = '{1'b0, 64, 8};
    tbl[1] = '{1'b1, 4095, -256};
    tbl[2] = '{1'b0, 4095, 255};
    tbl[3] = '{1'b0, 0, 0};
    tbl[4] = '{1'b1, 64, -8};

    repeat (3) tick();
    check("rst_ready", ready_idct, 1);
    check("rst_coef_next", coef_next, 0);
    check("rst_pix0", pixel_data0, 0);
    check("rst_pix1", pixel_data1, 0);
    reset_n = 1'b1;
    tick();
    check("post_rst_ready", ready_idct, 1);
    check("post_rst_coef_next", coef_next, 0);

    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 64; i++) cur_f[i] = 0;
      cur_f[0] = tbl[t].sgn ? -tbl[t].mag : tbl[t].mag;
      do_block(1, 1, 0, 0, -1);
      do_block(0, 0, 1, 1, -1);
      for (int a = 0; a < 32; a++) begin
        pixel_addr = 5'(a);
        pixel_coded = 1'b1;
        tick();
        check("dc_pix0", pixel_data0, tbl[t].exp_pix);
        check("dc_pix1", pixel_data1, tbl[t].exp_pix);
      end
      pixel_coded = 1'b0;
    end

    rand_block(3);
    do_block(1, 1, 0, 0, 200);
    read_all(0);
    do_block(0, 0, 1, 1, -1);
    read_all(0);

    do_block(0, 0, 1, 0, -1);
    read_all(0);
    do_block(0, 1, 0, 0, -1);
    read_all(1);

    for (int it = 0; it < 30; it++) begin
      rand_block(it % 8 + 1);
      do_block(1, 1, 1, $urandom_range(0, 7) != 0, -1);
      read_all(1);
    end
    do_block(0, 0, 1, 1, -1);
    read_all(1);

    rand_block(4);
    s2_enable = 1'b1;
    s2_coded = 1'b1;
    s3_enable = 1'b0;
    block_start = 1'b1;
    tick();
    block_start = 1'b0;
    repeat (20) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_coef_next", coef_next, 0);
    check("rst_mid_ready", ready_idct, 1);
    check("rst_mid_pix0", pixel_data0, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    comp_known = 0;
    out_known = 0;
    tick();
    do_block(1, 1, 0, 0, -1);
    do_block(0, 0, 1, 1, -1);
    read_all(0);

    rand_block(5);
    s2_enable = 1'b1;
    s2_coded = 1'b1;
    block_start = 1'b1;
    tick();
    block_start = 1'b0;
    repeat (800) tick();
    softreset = 1'b1;
    tick();
    softreset = 1'b0;
    check("srst_ready", ready_idct, 1);
    check("srst_coef_next", coef_next, 0);
    check("srst_pix0", pixel_data0, 0);
    check("srst_pix1", pixel_data1, 0);
    comp_known = 0;
    out_known = 0;
    rand_block(2);
    do_block(1, 1, 0, 0, -1);
    do_block(0, 0, 1, 1, -1);
    read_all(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/m2v_idct.md
Name: m2v_idct

Overview:
- 8x8 inverse DCT stage of the MPEG-2 video decoder. Sits between the coefficient/dequantiser stage (upstream) and motion-compensation/reconstruction (downstream).
- Pulls 64 sign-magnitude coefficients per coded block and computes a fixed-point separable 2-D IDCT.
- Double-buffers results so the previous block's 9-bit residual pixels can be read two at a time while the next block is computed.

Parameters:
- None. Coefficient width 12, pixel width 9, block 8x8 are fixed.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- softreset  in  1  synchronous clear; same effect as reset.
- ready_idct  out  1  compute stage idle, block_start accepted.
- block_start  in  1  one-cycle pulse that advances the block pipeline.
- s2_enable  in  1  incoming block exists; sampled at block_start.
- s2_coded  in  1  incoming block has coefficients; sampled at block_start.
- s3_enable  in  1  block leaving compute stage exists; sampled at block_start.
- s3_coded  in  1  block leaving compute stage is coded; sampled at block_start.
- coef_next  out  1  consume strobe for the current coefficient.
- coef_sign  in  1  coefficient sign (1 = negative).
- coef_data  in  12  coefficient magnitude.
- pixel_coded  in  1  read qualifier; 0 forces zero output.
- pixel_addr  in  5  pixel-pair address 0..31.
- pixel_data0  out  9  signed residual at pixel 2*addr.
- pixel_data1  out  9  signed residual at pixel 2*addr+1.

Behaviour:
Reset and softreset:
- ready_idct=1, coef_next=0, pixel_data0/1=0, FSM IDLE.
- Buffer contents undefined.

block_start:
- Honoured only while ready_idct=1. Ignored otherwise.
- On an accepted start:
  - If s3_enable=1, the compute buffer swaps into the output buffer. If s3_coded=0, the swapped-in block reads as all zeros.
  - If s3_enable=0, the output buffer is retained.
  - If s2_enable&s2_coded, go to LOAD. Otherwise ready_idct returns high 1 cycle later with no coef_next.
- ready_idct drops the cycle after the accepted start and stays low until COLPASS completes.

FSM: IDLE -> LOAD -> ROWPASS -> COLPASS -> IDLE.

LOAD:
- coef_next is high for exactly 64 single-cycle strobes. One strobe per coefficient, in raster order F[v][u], index = 8v+u.
- The coefficient is sampled on the cycle coef_next=1.
- Upstream presents the next value from the following cycle. There is at least 1 idle cycle between strobes.
- Value = coef_sign ? -coef_data : coef_data, 13-bit signed.

Transform (fixed point, bit-exact):
- Coefficient table: C[u][x] = round(4096 * c(u)/2 * cos((2x+1)u*pi/16)), with c(0)=1/sqrt2 and c(u>0)=1.
- ROWPASS: r[v][x] = (sum_u F[v][u]*C[u][x] + 256) >>> 9, arithmetic shift, stored 16-bit signed, saturating.
- COLPASS: p[y][x] = (sum_v r[v][x]*C[v][y] + 16384) >>> 15, then clipped to [-256, 255].
- Accumulators are at least 32 bits. A single serial MAC is acceptable.
- Total latency from block_start to ready_idct=1 is at most 1200 cycles for a coded block.

Pixel read:
- Synchronous read. pixel_data0/1 are registered one cycle after pixel_addr/pixel_coded are presented.
- Address mapping: row = addr[4:2], col0 = 2*addr[1:0], col1 = col0+1.
- pixel_coded=0 gives 0 on both outputs.
- Reading is always allowed, independent of compute state. The output buffer never changes except at an accepted block_start.

Boundary conditions:
- block_start while busy: ignored; no state change.
- Reset mid-LOAD: coef_next deasserts immediately; partial block discarded.
- s2_enable=0 with s2_coded=1: treated as not coded.
- Saturating values (coef_data=4095): clip to 255 or -256, never wrap.

Test Plan:
- Reset -> ready_idct=1, coef_next=0, pixel_data0/1=0.
- Coded block with F[0][0]=+64, rest 0 -> exactly 64 coef_next strobes. After the next block_start with s3_enable=s3_coded=1, all 64 pixels read 8 (pixel_coded=1).
- F[0][0]: sign=1, data=4095 -> all pixels clip to -256. F[0][0]=+4095 -> all 255.
- Block with s2_coded=0 -> no coef_next, ready_idct high 1 cycle after start. Swapped block with s3_coded=0 reads 0 everywhere.
- block_start pulsed during ROWPASS -> ignored; coef_next count and result unchanged.
- Random coded blocks (e.g. 1000) compared bit-exactly against the fixed-point model; pixel_coded=0 on any read -> 0/0.
